// File: rtl/ram_mm_pkg.sv
// ---------------------------------------------------------------------------
// ram_mm_pkg
// Shared constants and the request record for the on-chip RAM arbiter slice.
//   RAM_MM_AW / RAM_MM_DW / RAM_MM_BW : default word address, data and
//                                       byte-enable widths
//   ram_mm_req_t                      : one queued request
//                                       {write, address, writedata, byteenable}
// ---------------------------------------------------------------------------
package ram_mm_pkg;

    localparam int unsigned RAM_MM_AW = 13;
    localparam int unsigned RAM_MM_DW = 32;
    localparam int unsigned RAM_MM_BW = RAM_MM_DW / 8;

    typedef struct packed {
        logic                 write;
        logic [RAM_MM_AW-1:0] address;
        logic [RAM_MM_DW-1:0] writedata;
        logic [RAM_MM_BW-1:0] byteenable;
    } ram_mm_req_t;

endpackage

// File: rtl/ram_mm_req_fifo.sv
// ---------------------------------------------------------------------------
// ram_mm_req_fifo
// Per-channel request queue, DEPTH entries (power of 2, >= 2), W bits wide.
//   clk, rst_n      : clock, asynchronous active-low reset (clears pointers)
//   push, push_data : enqueue request
//   pop, pop_data   : dequeue; pop_data shows the head entry (first-word
//                     fall-through)
//   full, empty     : level flags, decoded from registered pointers only
// ---------------------------------------------------------------------------
module ram_mm_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    // One extra wrap bit distinguishes full from empty when the indices match.
    logic [PW:0]  wr_ptr;
    logic [PW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) &&
                      (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop   = pop && !empty;
    // A push against a full queue still lands when the head leaves the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/ram_mm_arbiter.sv
// ---------------------------------------------------------------------------
// ram_mm_arbiter
// Round-robin arbiter sharing one on-chip RAM slave between N_CH requesters.
// Each channel has its own request FIFO; one FIFO is granted per cycle and
// its head entry is issued as a registered RAM command. Read returns are
// routed back through an RD_LAT-deep {valid, channel} shift register.
//   clk_clk, reset_reset_n : clock, asynchronous active-low reset
//   ch_valid/ch_ready      : per-channel request handshake
//   ch_write, ch_address, ch_writedata, ch_byteenable : packed request fields
//   ch_rvalid, ch_readdata : one-hot read-return strobe, shared read data
//   ram_mm_*               : registered command bus to the RAM slave,
//                            ram_mm_readdata returns from it
// ---------------------------------------------------------------------------
module ram_mm_arbiter
    import ram_mm_pkg::*;
#(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned AW     = RAM_MM_AW,
    parameter int unsigned DW     = RAM_MM_DW,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk_clk,
    input  logic               reset_reset_n,
    input  logic [N_CH-1:0]    ch_valid,
    output logic [N_CH-1:0]    ch_ready,
    input  logic [N_CH-1:0]    ch_write,
    input  logic [N_CH*AW-1:0] ch_address,
    input  logic [N_CH*DW-1:0] ch_writedata,
    input  logic [N_CH*(DW/8)-1:0] ch_byteenable,
    output logic [N_CH-1:0]    ch_rvalid,
    output logic [DW-1:0]      ch_readdata,
    output logic [AW-1:0]      ram_mm_address,
    output logic               ram_mm_chipselect,
    output logic               ram_mm_clken,
    output logic               ram_mm_write,
    output logic [DW-1:0]      ram_mm_writedata,
    output logic [DW/8-1:0]    ram_mm_byteenable,
    input  logic [DW-1:0]      ram_mm_readdata
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned CW = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef struct packed {
        logic          write;
        logic [AW-1:0] address;
        logic [DW-1:0] writedata;
        logic [BW-1:0] byteenable;
    } req_t;

    localparam int unsigned RW = $bits(req_t);

    logic [N_CH-1:0] fifo_full;
    logic [N_CH-1:0] fifo_empty;
    logic [N_CH-1:0] push_en;
    logic [N_CH-1:0] pop_en;
    logic [RW-1:0]   pop_data [N_CH];

    logic [CW-1:0]   rr_ptr;
    logic [CW-1:0]   grant_id;
    logic            grant_any;
    req_t            gnt_req;
    logic [CW-1:0]   cmd_id;

    logic [RD_LAT-1:0]    rd_vld;
    logic [RD_LAT*CW-1:0] rd_id;
    logic                 ret_vld;
    logic [CW-1:0]        ret_id;

    // ---------------------------------------------------------------- FIFOs
    assign ch_ready = ~fifo_full;
    assign push_en  = ch_valid & ~fifo_full;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        ram_mm_req_fifo #(
            .DEPTH (DEPTH),
            .W     (RW)
        ) u_fifo (
            .clk       (clk_clk),
            .rst_n     (reset_reset_n),
            .push      (push_en[g]),
            .push_data ({ch_write[g],
                         ch_address[g*AW +: AW],
                         ch_writedata[g*DW +: DW],
                         ch_byteenable[g*BW +: BW]}),
            .pop       (pop_en[g]),
            .pop_data  (pop_data[g]),
            .full      (fifo_full[g]),
            .empty     (fifo_empty[g])
        );
    end

    // ------------------------------------------------------------- arbiter
    // Scan from rr_ptr upward (mod N_CH); first non-empty FIFO wins.
    always_comb begin : arb
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_id  = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            idx = (32'(rr_ptr) + i) % N_CH;
            if (!grant_any && !fifo_empty[CW'(idx)]) begin
                grant_any = 1'b1;
                grant_id  = CW'(idx);
            end
        end
    end

    always_comb begin
        pop_en = '0;
        if (grant_any) pop_en[grant_id] = 1'b1;
    end

    assign gnt_req = req_t'(pop_data[grant_id]);

    // ------------------------------------------------------ RAM command bus
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rr_ptr            <= '0;
            cmd_id            <= '0;
            ram_mm_clken      <= 1'b0;
            ram_mm_chipselect <= 1'b0;
            ram_mm_write      <= 1'b0;
            ram_mm_address    <= '0;
            ram_mm_writedata  <= '0;
            ram_mm_byteenable <= '0;
        end else begin
            ram_mm_clken      <= 1'b1;
            ram_mm_chipselect <= grant_any;
            ram_mm_write      <= grant_any & gnt_req.write;
            cmd_id            <= grant_id;
            // Address/data/byteenable hold their last values while idle.
            if (grant_any) begin
                rr_ptr            <= (32'(grant_id) == N_CH - 1) ? '0 : grant_id + 1'b1;
                ram_mm_address    <= gnt_req.address;
                ram_mm_writedata  <= gnt_req.writedata;
                ram_mm_byteenable <= gnt_req.byteenable;
            end
        end
    end

    // ------------------------------------------------ read-return pipeline
    // Stage 0 captures the read command visible on the bus this cycle, so
    // the last stage lines up with the RAM's data RD_LAT cycles later.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rd_vld <= '0;
            rd_id  <= '0;
        end else begin
            rd_vld <= RD_LAT'({rd_vld, ram_mm_chipselect & ~ram_mm_write});
            rd_id  <= (RD_LAT*CW)'({rd_id, cmd_id});
        end
    end

    assign ret_vld = rd_vld[RD_LAT-1];
    assign ret_id  = rd_id[(RD_LAT-1)*CW +: CW];

    always_comb begin
        ch_rvalid   = '0;
        ch_readdata = '0;
        if (ret_vld) begin
            ch_rvalid[ret_id] = 1'b1;
            ch_readdata       = ram_mm_readdata;
        end
    end

endmodule

// File: doc/ram_mm_arbiter.md
RAM_MM_ARBITER -- requirements
Module: ram_mm_arbiter

Interface
REQ-001 Parameter N_CH, default 4, number of requester channels (1..8).
REQ-002 Parameter AW, default 13, word address width.
REQ-003 Parameter DW, default 32, data width; multiple of 8; BW = DW/8.
REQ-004 Parameter DEPTH, default 4, per-channel request FIFO entries; power of 2, >=2.
REQ-005 Parameter RD_LAT, default 1, RAM read latency in cycles (1 or 2).
REQ-006 Port clk_clk  in  1  sole clock; all logic rising-edge.
REQ-007 Port reset_reset_n  in  1  asynchronous, active-low reset.
REQ-008 Port ch_valid  in  N_CH  per-channel request valid.
REQ-009 Port ch_ready  out  N_CH  per-channel FIFO not full.
REQ-010 Port ch_write  in  N_CH  1 = write, 0 = read.
REQ-011 Port ch_address  in  N_CH*AW  packed addresses, channel i at [i*AW +: AW].
REQ-012 Port ch_writedata  in  N_CH*DW  packed write data.
REQ-013 Port ch_byteenable  in  N_CH*BW  packed byte enables.
REQ-014 Port ch_rvalid  out  N_CH  one-cycle read-return strobe, one-hot or zero.
REQ-015 Port ch_readdata  out  DW  shared read data, valid when any ch_rvalid is high.
REQ-016 Ports ram_mm_address (AW), ram_mm_chipselect (1), ram_mm_clken (1), ram_mm_write (1), ram_mm_writedata (DW), ram_mm_byteenable (BW)  out; ram_mm_readdata (DW)  in. These drive the on-chip RAM slave.

Function
REQ-017 Request accepted when ch_valid[i] and ch_ready[i] are high at a rising edge; the entry is pushed into FIFO i.
REQ-018 ch_ready[i] = FIFO i not full, from registered state only; a pop in the same cycle does not raise ready combinationally.
REQ-019 Simultaneous push and pop on a full or non-empty FIFO both take effect; level unchanged; pointers wrap modulo DEPTH.
REQ-020 Arbiter grants at most one non-empty FIFO per cycle, round-robin, starting at (last grant + 1) mod N_CH; the granted FIFO pops.
REQ-021 All ram_mm outputs registered; an uncontested request accepted in cycle k appears on the bus in cycle k+2 with chipselect=1 for exactly one cycle.
REQ-022 No grant -> ram_mm_chipselect=0, ram_mm_write=0; address, data and byteenable hold their last values.
REQ-023 ram_mm_clken = 1 whenever reset is deasserted.
REQ-024 Read command in cycle c -> ch_rvalid[granted channel]=1 in cycle c+RD_LAT; ch_readdata = ram_mm_readdata in that cycle. Implemented via an RD_LAT-deep shift register of {valid, channel id}.
REQ-025 Per-channel order preserved; a read issued after a write to the same address on the same channel returns the new data.
REQ-026 Back-to-back grants sustain one command per cycle, with reads and writes interleaved freely.

Reset
REQ-027 Asynchronous assertion clears all FIFO pointers, the round-robin pointer (next grant = channel 0) and the read-return pipeline.
REQ-028 Reset values: ch_ready all ones; ch_rvalid 0; ch_readdata 0; ram_mm_chipselect, ram_mm_write and ram_mm_clken 0; address, writedata and byteenable 0.
REQ-029 Pushes are ignored while reset is asserted.
REQ-030 Reads in flight when reset is asserted are discarded; no ch_rvalid occurs after release for them.

Structure
REQ-031 Package ram_mm_pkg holds default AW/DW constants and the request record typedef {write, address, writedata, byteenable}.
REQ-032 One sub-module, ram_mm_req_fifo (parametrised by DEPTH and record width), is instantiated N_CH times; arbitration and the return pipeline stay in the top level.

Verification
REQ-033 Single write, ch0 addr 0x010, data 0xDEADBEEF, be 0xF, accepted cycle k -> chipselect=1, write=1, addr 0x010 in cycle k+2 only.
REQ-034 All 4 channels push one write in the same cycle -> grants issued in order 0,1,2,3 on consecutive cycles; the next simultaneous burst starts at 0 after the grant pointer wraps.
REQ-035 ch2 pushes DEPTH=4 writes while the bus is occupied by other channels -> ch_ready[2]=0 after the 4th push; a 5th valid is not accepted; ready returns the cycle after the first ch2 pop.
REQ-036 ch1 writes 0x12345678 to 0x1FFF, then reads 0x1FFF, RD_LAT=2 -> ch_rvalid=0b0010 exactly 2 cycles after the read command, with ch_readdata 0x12345678.
REQ-037 Reset is asserted with 3 entries queued and 1 read in flight -> no chipselect and no ch_rvalid after release; ch_ready all ones.
REQ-038 Byteenable 0x3 write of 0xAABBCCDD over 0x00000000, then read -> returns 0x0000CCDD.
